alu_decoder: RTL and testbench

ALU_DECODER -- requirements
Module: alu_decoder

---
 rtl/alu_decoder.sv | 219 +++++++++++++++++++++
 tb/tb_alu_decoder.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_decoder.sv
// RV32I ALU-class instruction decoder with a valid/ready output register stage.
// Define ALU_DECODER_SKID_EN to add a skid register so that ready_o is fully registered.
module alu_decoder (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [3:0]  alu_op_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rd_o,
    output logic [31:0] imm_o,
    output logic        use_imm_o,
    output logic        use_pc_o,
    output logic [31:0] pc_o,
    output logic        we_o,
    output logic        illegal_o
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SRA    = 4'b1101;

    typedef struct packed {
        logic [3:0]  alu_op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        use_imm;
        logic        use_pc;
        logic [31:0] pc;
        logic        we;
        logic        illegal;
    } bundle_t;

    typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_e;

    function automatic bundle_t decode(input logic [31:0] instr, input logic [31:0] pc);
        bundle_t           b;
        logic              legal;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic signed [11:0] imm_i;
        b      = '0;
        b.pc   = pc;
        b.rd   = instr[11:7];
        legal  = 1'b0;
        funct3 = instr[14:12];
        funct7 = instr[31:25];
        imm_i  = instr[31:20];
        if (instr[1:0] == 2'b11) begin
            case (instr[6:0])
                OPC_OP: begin
                    b.rs1    = instr[19:15];
                    b.rs2    = instr[24:20];
                    b.alu_op = {instr[30], funct3};
                    legal    = (funct7 == 7'b0000000) ||
                               (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
                end
                OPC_OP_IMM: begin
                    b.rs1     = instr[19:15];
                    b.use_imm = 1'b1;
                    b.imm     = 32'(imm_i);
                    b.alu_op  = {1'b0, funct3};
                    legal     = 1'b1;
                    // Shifts carry a 5-bit shamt; the upper field only selects SRL vs SRA.
                    if (funct3 == 3'b001) begin
                        legal = (funct7 == 7'b0000000);
                        b.imm = {27'b0, instr[24:20]};
                    end else if (funct3 == 3'b101) begin
                        legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                        b.imm = {27'b0, instr[24:20]};
                        if (instr[30]) b.alu_op = ALU_SRA;
                    end
                end
                OPC_LUI: begin
                    b.use_imm = 1'b1;
                    b.imm     = {instr[31:12], 12'b0};
                    legal     = 1'b1;
                end
                OPC_AUIPC: begin
                    b.use_pc  = 1'b1;
                    b.use_imm = 1'b1;
                    b.imm     = {instr[31:12], 12'b0};
                    legal     = 1'b1;
                end
                default: legal = 1'b0;
            endcase
        end
        if (!legal) begin
            b.illegal = 1'b1;
            b.alu_op  = ALU_ADD;
        end
        b.we = legal && (b.rd != 5'd0);
        return b;
    endfunction

    state_e  state_q, state_d;
    bundle_t dec_p0;
    bundle_t out_p1;
    logic    in_xfer, out_xfer, load_out;

    assign dec_p0   = decode(instr_i, pc_i);
    assign valid_o  = (state_q != ST_EMPTY);
    assign in_xfer  = valid_i && ready_o;
    assign out_xfer = valid_o && ready_i;

`ifdef ALU_DECODER_SKID_EN
    bundle_t skid_p1;
    logic    load_skid, out_from_skid;

    assign ready_o = (state_q != ST_SKID);

    always_comb begin
        state_d       = state_q;
        load_out      = 1'b0;
        load_skid     = 1'b0;
        out_from_skid = 1'b0;
        case (state_q)
            ST_EMPTY: if (in_xfer) begin
                state_d  = ST_FULL;
                load_out = 1'b1;
            end
            ST_FULL: begin
                if (in_xfer && ready_i) begin
                    load_out = 1'b1;
                end else if (in_xfer) begin
                    state_d   = ST_SKID;
                    load_skid = 1'b1;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_SKID: if (out_xfer) begin
                state_d       = ST_FULL;
                out_from_skid = 1'b1;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            skid_p1 <= '0;
        end else if (load_skid) begin
            skid_p1 <= dec_p0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_p1 <= '0;
        end else if (load_out) begin
            out_p1 <= dec_p0;
        end else if (out_from_skid) begin
            out_p1 <= skid_p1;
        end
    end
`else
    // Without a skid buffer an accept while full always coincides with an output transfer.
    assign ready_o = !valid_o || ready_i;

    always_comb begin
        state_d  = state_q;
        load_out = 1'b0;
        case (state_q)
            ST_EMPTY: if (in_xfer) begin
                state_d  = ST_FULL;
                load_out = 1'b1;
            end
            ST_FULL: begin
                if (in_xfer) begin
                    load_out = 1'b1;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_p1 <= '0;
        end else if (load_out) begin
            out_p1 <= dec_p0;
        end
    end
`endif

    // Stage p1 boundary: registered bundle drives the ALU stage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    assign alu_op_o  = out_p1.alu_op;
    assign rs1_o     = out_p1.rs1;
    assign rs2_o     = out_p1.rs2;
    assign rd_o      = out_p1.rd;
    assign imm_o     = out_p1.imm;
    assign use_imm_o = out_p1.use_imm;
    assign use_pc_o  = out_p1.use_pc;
    assign pc_o      = out_p1.pc;
    assign we_o      = out_p1.we;
    assign illegal_o = out_p1.illegal;

endmodule

// File: tb/tb_alu_decoder.sv
// Testbench for alu_decoder: directed vector table, handshake corner sequences and
// randomized traffic scored against a queue-based reference decoder.
module tb_alu_decoder;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] instr_i = '0;
    logic [31:0] pc_i = '0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [3:0]  alu_op_o;
    logic [4:0]  rs1_o, rs2_o, rd_o;
    logic [31:0] imm_o, pc_o;
    logic        use_imm_o, use_pc_o, we_o, illegal_o;

    alu_decoder dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
        .instr_i(instr_i), .pc_i(pc_i), .valid_o(valid_o), .ready_i(ready_i),
        .alu_op_o(alu_op_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
        .imm_o(imm_o), .use_imm_o(use_imm_o), .use_pc_o(use_pc_o), .pc_o(pc_o),
        .we_o(we_o), .illegal_o(illegal_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [3:0]  alu_op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        use_imm;
        logic        use_pc;
        logic        we;
        logic        illegal;
        logic        chk_rs1;
        logic        chk_rs2;
        logic        chk_imm;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        exp_t        e;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   in_cnt = 0;
    int   out_cnt = 0;
    exp_t q[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic cmp_bundle(input string pfx, input exp_t e);
        chk({pfx, ".illegal"}, 32'(illegal_o), 32'(e.illegal));
        chk({pfx, ".we"}, 32'(we_o), 32'(e.we));
        chk({pfx, ".alu_op"}, 32'(alu_op_o), 32'(e.alu_op));
        chk({pfx, ".pc"}, pc_o, e.pc);
        if (!e.illegal) begin
            chk({pfx, ".rd"}, 32'(rd_o), 32'(e.rd));
            chk({pfx, ".use_imm"}, 32'(use_imm_o), 32'(e.use_imm));
            chk({pfx, ".use_pc"}, 32'(use_pc_o), 32'(e.use_pc));
            if (e.chk_rs1) chk({pfx, ".rs1"}, 32'(rs1_o), 32'(e.rs1));
            if (e.chk_rs2) chk({pfx, ".rs2"}, 32'(rs2_o), 32'(e.rs2));
            if (e.chk_imm) chk({pfx, ".imm"}, imm_o, e.imm);
        end
    endtask

    // Reference decoder: instruction-set rules expressed with plain integer arithmetic.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        int   op, f3, f7;
        bit   legal;
        op = int'(ins[6:0]);
        f3 = int'(ins[14:12]);
        f7 = int'(ins[31:25]);
        e = '0;
        e.pc = pc;
        e.rd = ins[11:7];
        legal = 0;
        if (ins[1:0] == 2'b11) begin
            if (op == 'h33) begin
                legal = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
                e.alu_op = 4'((f7 == 32 ? 8 : 0) + f3);
                e.rs1 = ins[19:15];
                e.rs2 = ins[24:20];
                e.chk_rs1 = 1;
                e.chk_rs2 = 1;
            end else if (op == 'h13) begin
                e.use_imm = 1;
                e.rs1 = ins[19:15];
                e.chk_rs1 = 1;
                e.chk_imm = 1;
                if (f3 == 1 || f3 == 5) begin
                    legal = (f7 == 0) || (f3 == 5 && f7 == 32);
                    e.imm = 32'(int'(ins[24:20]));
                    e.alu_op = 4'((f3 == 5 && f7 == 32) ? 13 : f3);
                end else begin
                    legal = 1;
                    e.imm = 32'($signed(ins[31:20]));
                    e.alu_op = 4'(f3);
                end
            end else if (op == 'h37 || op == 'h17) begin
                legal = 1;
                e.use_imm = 1;
                e.use_pc = (op == 'h17);
                e.imm = ins & 32'hFFFF_F000;
                e.chk_imm = 1;
                e.chk_rs1 = (op == 'h37);
            end
        end
        e.illegal = !legal;
        if (!legal) e.alu_op = 4'd0;
        e.we = legal && (e.rd != 0);
        return e;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] r;
        logic [6:0]  f7;
        r = $urandom;
        case ($urandom_range(0, 3))
            0, 1:    f7 = 7'h00;
            2:       f7 = 7'h20;
            default: f7 = r[31:25];
        endcase
        case ($urandom_range(0, 6))
            0: begin r[31:25] = f7; r[6:0] = 7'h33; end
            1: r[6:0] = 7'h13;
            2: begin r[31:25] = f7; r[14:12] = ($urandom_range(0, 1) != 0) ? 3'd1 : 3'd5; r[6:0] = 7'h13; end
            3: r[6:0] = 7'h37;
            4: r[6:0] = 7'h17;
            5: ;
            default: begin r[6:0] = 7'h33; r[1:0] = 2'($urandom_range(0, 2)); end
        endcase
        return r;
    endfunction

    // Scoreboard monitor: inputs change just after posedge, so negedge sees the handshake.
    bit          hold_v = 0;
    bit          lat_pend = 0;
    logic [22:0] hold_ctl;
    logic [31:0] hold_imm, hold_pc;

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            hold_v = 0;
            lat_pend = 0;
        end else begin
            if (lat_pend) chk("latency.valid_o", 32'(valid_o), 32'd1);
            lat_pend = 0;
            if (hold_v) begin
                chk("hold.valid_o", 32'(valid_o), 32'd1);
                chk("hold.ctl", 32'({alu_op_o, rs1_o, rs2_o, rd_o, use_imm_o, use_pc_o, we_o, illegal_o}), 32'(hold_ctl));
                chk("hold.imm", imm_o, hold_imm);
                chk("hold.pc", pc_o, hold_pc);
            end
            hold_v = valid_o && !ready_i;
            hold_ctl = {alu_op_o, rs1_o, rs2_o, rd_o, use_imm_o, use_pc_o, we_o, illegal_o};
            hold_imm = imm_o;
            hold_pc = pc_o;
            if (valid_o && ready_i) begin
                out_cnt++;
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb.unexpected_bundle: got pc %h expected no bundle", pc_o);
                end else begin
                    cmp_bundle("sb", q.pop_front());
                end
            end
            if (valid_i && ready_o) begin
                in_cnt++;
                q.push_back(ref_decode(instr_i, pc_i));
                if (!valid_o) lat_pend = 1;
            end
        end
    end

    task automatic drain(input string name);
        int cyc;
        valid_i = 1'b0;
        ready_i = 1'b1;
        cyc = 0;
        while ((q.size() != 0 || valid_o) && cyc < 40) begin
            @(negedge clk_i);
            #1;
            cyc++;
        end
        chk({name, ".drain_left"}, 32'(q.size()), 32'd0);
        chk({name, ".drain_valid"}, 32'(valid_o), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    vec_t tbl[12];

    initial begin
        exp_t e;
        int   c0;
        tbl[0]  = '{32'h003100B3, '{4'h0, 5'd2, 5'd3, 5'd1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0}};
        tbl[1]  = '{32'h4020D093, '{4'hD, 5'd1, 5'd0, 5'd1, 32'h2, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1}};
        tbl[2]  = '{32'hFFF00093, '{4'h0, 5'd0, 5'd0, 5'd1, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1}};
        tbl[3]  = '{32'h123450B7, '{4'h0, 5'd0, 5'd0, 5'd1, 32'h12345000, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1}};
        tbl[4]  = '{32'h02000033, '{4'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}};
        tbl[5]  = '{32'h407302B3, '{4'h8, 5'd6, 5'd7, 5'd5, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0}};
        tbl[6]  = '{32'h00001197, '{4'h0, 5'd0, 5'd0, 5'd3, 32'h1000, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}};
        tbl[7]  = '{32'h00208033, '{4'h0, 5'd1, 5'd2, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}};
        tbl[8]  = '{32'h00000000, '{4'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}};
        tbl[9]  = '{32'h0020B233, '{4'h3, 5'd1, 5'd2, 5'd4, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0}};
        tbl[10] = '{32'h40109093, '{4'h0, 5'd0, 5'd0, 5'd1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}};
        tbl[11] = '{32'h4041D133, '{4'hD, 5'd3, 5'd4, 5'd2, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0}};

        // Reset state, asynchronously before any clock edge.
        #3;
        chk("rst.valid_o", 32'(valid_o), 32'd0);
        chk("rst.ctl", 32'({alu_op_o, rs1_o, rs2_o, rd_o, use_imm_o, use_pc_o, we_o, illegal_o}), 32'd0);
        chk("rst.imm", imm_o, 32'd0);
        chk("rst.pc", pc_o, 32'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        ready_i = 1'b1;
        chk("rst.ready_after", 32'(ready_o), 32'd1);

        // Directed vector table, one instruction at a time.
        for (int i = 0; i < 12; i++) begin
            @(posedge clk_i);
            #1;
            valid_i = 1'b1;
            instr_i = tbl[i].instr;
            pc_i = $urandom & 32'hFFFF_FFFC;
            e = tbl[i].e;
            e.pc = pc_i;
            @(posedge clk_i);
            #1;
            valid_i = 1'b0;
            chk($sformatf("tbl%0d.valid_o", i), 32'(valid_o), 32'd1);
            cmp_bundle($sformatf("tbl%0d", i), e);
        end
        drain("tbl");

        // Back-pressure: three instructions offered while the ALU stage stalls.
        c0 = in_cnt;
        ready_i = 1'b0;
        @(posedge clk_i);
        #1;
        valid_i = 1'b1;
        instr_i = 32'h003100B3;
        pc_i = 32'h100;
        chk("bp.ready0", 32'(ready_o), 32'd1);
`ifdef ALU_DECODER_SKID_EN
        @(posedge clk_i);
        #1;
        instr_i = 32'h4020D093;
        pc_i = 32'h104;
        chk("bp.ready1", 32'(ready_o), 32'd1);
        @(posedge clk_i);
        #1;
        instr_i = 32'hFFF00093;
        pc_i = 32'h108;
        chk("bp.ready2", 32'(ready_o), 32'd0);
        @(posedge clk_i);
        #1;
        chk("bp.ready3", 32'(ready_o), 32'd0);
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("bp.ready4", 32'(ready_o), 32'd1);
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
`else
        @(posedge clk_i);
        #1;
        instr_i = 32'h4020D093;
        pc_i = 32'h104;
        chk("bp.ready1", 32'(ready_o), 32'd0);
        @(posedge clk_i);
        #1;
        chk("bp.ready2", 32'(ready_o), 32'd0);
        ready_i = 1'b1;
        #1;
        chk("bp.ready3", 32'(ready_o), 32'd1);
        @(posedge clk_i);
        #1;
        instr_i = 32'hFFF00093;
        pc_i = 32'h108;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
`endif
        drain("bp");
        chk("bp.accepted", 32'(in_cnt - c0), 32'd3);

        // Streaming: eight instructions on eight consecutive cycles.
        c0 = out_cnt;
        ready_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk_i);
            #1;
            valid_i = 1'b1;
            instr_i = gen_instr();
            pc_i = 32'h200 + 32'(4 * k);
            chk($sformatf("stream%0d.ready_o", k), 32'(ready_o), 32'd1);
        end
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        @(negedge clk_i);
        #1;
        chk("stream.out_count", 32'(out_cnt - c0), 32'd8);
        drain("stream");

        // Reset while bundles are buffered.
        ready_i = 1'b0;
        @(posedge clk_i);
        #1;
        valid_i = 1'b1;
        instr_i = 32'h003100B3;
        pc_i = 32'h300;
        @(posedge clk_i);
        #1;
        instr_i = 32'h123450B7;
        pc_i = 32'h304;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        chk("rstmid.pre_valid", 32'(valid_o), 32'd1);
        #1;
        rst_ni = 1'b0;
        #1;
        q.delete();
        in_cnt = out_cnt;
        chk("rstmid.valid_o", 32'(valid_o), 32'd0);
        chk("rstmid.ctl", 32'({alu_op_o, rs1_o, rs2_o, rd_o, use_imm_o, use_pc_o, we_o, illegal_o}), 32'd0);
        chk("rstmid.imm", imm_o, 32'd0);
        chk("rstmid.pc", pc_o, 32'd0);
        @(posedge clk_i);
        #1;
        chk("rstmid.hold_valid", 32'(valid_o), 32'd0);
        rst_ni = 1'b1;
        #1;
        chk("rstmid.ready_o", 32'(ready_o), 32'd1);
        ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i);
            #1;
            chk($sformatf("rstmid.stale%0d", k), 32'(valid_o), 32'd0);
        end

        // Randomized traffic against the scoreboard.
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk_i);
            #1;
            valid_i = ($urandom_range(0, 3) != 0);
            ready_i = ($urandom_range(0, 2) != 0);
            instr_i = gen_instr();
            pc_i = $urandom & 32'hFFFF_FFFC;
        end
        drain("rand");
        chk("rand.in_eq_out", 32'(in_cnt), 32'(out_cnt));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
